ita_tcdm_splitter: RTL and testbench

ITA_TCDM_SPLITTER -- requirements
Module: ita_tcdm_splitter

---
 rtl/ita_tcdm_splitter.sv | 196 +++++++++++++++++++
 tb/tb_ita_tcdm_splitter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ita_tcdm_splitter.sv
// ita_tcdm_splitter
//   Splits one wide TCDM request into MP narrow TCDM requests, one per port. Port i
//   covers bytes [i*MemDataWidth/8 +: MemDataWidth/8] of the wide word, so port 0
//   carries the least significant slice. Narrow grants may arrive on different cycles.
//   The wide grant is given in the cycle in which the last missing narrow grant
//   arrives. Narrow responses are queued in per-port FIFOs. A wide response is
//   produced once every port has at least one queued response.
//
// Optional feature (macro ITA_TCDM_SPLIT_ERR_EN):
//   When defined, err_o goes sticky high when a narrow response arrives while that
//   port's FIFO is full. The response data is dropped. When undefined, err_o is tied
//   low and no error logic is built.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   wide_req_i/gnt_o    wide request handshake; the request fields are held until
//                       the grant
//   wide_add_i          wide byte address
//   wide_wen_i          1 = read
//   wide_be_i           wide byte enables
//   wide_data_i         wide write data
//   wide_r_data_o       wide response data
//   wide_r_valid_o      wide response valid
//   tcdm_*_o            per-port narrow request: req, add, wen, be, data
//   tcdm_gnt_i          per-port narrow grant
//   tcdm_r_data_i       per-port narrow response data
//   tcdm_r_valid_i      per-port narrow response valid
//   err_o               sticky protocol error (FIFO overflow)
module ita_tcdm_splitter #(
   parameter int unsigned MemDataWidth = 64,
   parameter int unsigned MP           = 16,
   parameter int unsigned AccDataWidth = MP * MemDataWidth,
   parameter int unsigned Depth        = 2
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 wide_req_i,
   output logic                                 wide_gnt_o,
   input  logic [31:0]                          wide_add_i,
   input  logic                                 wide_wen_i,
   input  logic [AccDataWidth/8-1:0]            wide_be_i,
   input  logic [AccDataWidth-1:0]              wide_data_i,
   output logic [AccDataWidth-1:0]              wide_r_data_o,
   output logic                                 wide_r_valid_o,
   output logic [MP-1:0]                        tcdm_req_o,
   output logic [MP-1:0][31:0]                  tcdm_add_o,
   output logic [MP-1:0]                        tcdm_wen_o,
   output logic [MP-1:0][MemDataWidth/8-1:0]    tcdm_be_o,
   output logic [MP-1:0][MemDataWidth-1:0]      tcdm_data_o,
   input  logic [MP-1:0]                        tcdm_gnt_i,
   input  logic [MP-1:0][MemDataWidth-1:0]      tcdm_r_data_i,
   input  logic [MP-1:0]                        tcdm_r_valid_i,
   output logic                                 err_o
);

   localparam int unsigned BeW  = MemDataWidth / 8;
   localparam int unsigned CntW = $clog2(Depth + 1);
   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

   localparam logic [0:0] StIdle    = 1'b0;
   localparam logic [0:0] StPartial = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [MP-1:0] granted_q, granted_d;
   logic [MP-1:0] accept, done_mask;
   logic [CntW-1:0] out_cnt_q, out_cnt_d;
   logic          rst_q;
   logic          hold;
   logic          stall;
   logic          pop;
   logic [MP-1:0] fifo_full, fifo_nonempty;
   logic [MP-1:0][MemDataWidth-1:0] fifo_head;

   // Outputs stay quiet while reset is asserted and for one cycle after it.
   assign hold = rst_i | rst_q;

   // Only a fresh transaction (nothing granted yet) is throttled by the outstanding
   // limit. A transaction that is already partially granted always finishes.
   assign stall = (out_cnt_q == CntW'(Depth)) && (granted_q == '0);

   always_comb begin
      tcdm_req_o = wide_req_i ? ~granted_q : '0;
      if (stall || hold) begin
         tcdm_req_o = '0;
      end
      accept     = tcdm_req_o & tcdm_gnt_i;
      done_mask  = granted_q | accept;
      wide_gnt_o = wide_req_i & ~stall & ~hold & (&done_mask);
   end

   always_comb begin
      granted_d = granted_q | accept;
      state_d   = state_q;
      if (wide_gnt_o) begin
         granted_d = '0;
         state_d   = StIdle;
      end else if (accept != '0) begin
         state_d   = StPartial;
      end
   end

   always_comb begin
      out_cnt_d = out_cnt_q;
      if (wide_gnt_o && !pop) begin
         out_cnt_d = out_cnt_q + CntW'(1);
      end else if (!wide_gnt_o && pop) begin
         out_cnt_d = out_cnt_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         granted_q <= '0;
         out_cnt_q <= '0;
         rst_q     <= 1'b1;
      end else begin
         state_q   <= state_d;
         granted_q <= granted_d;
         out_cnt_q <= out_cnt_d;
         rst_q     <= 1'b0;
      end
   end

   // The wide response is driven from FIFO state only, so it appears one cycle after
   // the last narrow response of a transaction.
   assign wide_r_valid_o = (&fifo_nonempty) & ~rst_i;
   assign pop            = wide_r_valid_o;

   for (genvar i = 0; i < MP; i++) begin : g_port
      logic [MemDataWidth-1:0] mem_q [Depth];
      logic [PtrW-1:0]         wptr_q, rptr_q;
      logic [CntW-1:0]         cnt_q;
      logic                    push;

      assign tcdm_add_o[i]  = wide_add_i + 32'(i * BeW);
      assign tcdm_wen_o[i]  = wide_wen_i;
      assign tcdm_be_o[i]   = wide_be_i[i*BeW +: BeW];
      assign tcdm_data_o[i] = wide_data_i[i*MemDataWidth +: MemDataWidth];

      assign fifo_full[i]     = (cnt_q == CntW'(Depth));
      assign fifo_nonempty[i] = (cnt_q != '0);
      assign fifo_head[i]     = mem_q[rptr_q];
      // A full FIFO still accepts data when it is popped in the same cycle.
      assign push             = tcdm_r_valid_i[i] & (~fifo_full[i] | pop);

      assign wide_r_data_o[i*MemDataWidth +: MemDataWidth] =
         wide_r_valid_o ? fifo_head[i] : '0;

      always_ff @(posedge clk_i) begin
         if (push) begin
            mem_q[wptr_q] <= tcdm_r_data_i[i];
         end
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
         end else begin
            if (push) begin
               wptr_q <= (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + PtrW'(1);
            end
            if (pop) begin
               rptr_q <= (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + PtrW'(1);
            end
            unique case ({push, pop})
               2'b10:   cnt_q <= cnt_q + CntW'(1);
               2'b01:   cnt_q <= cnt_q - CntW'(1);
               default: cnt_q <= cnt_q;
            endcase
         end
      end
   end

`ifdef ITA_TCDM_SPLIT_ERR_EN
   logic          err_q;
   logic [MP-1:0] overflow;

   assign overflow = tcdm_r_valid_i & fifo_full & ~{MP{pop}};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_q <= 1'b0;
      end else if (overflow != '0) begin
         err_q <= 1'b1;
      end
   end

   assign err_o = err_q & ~rst_i;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ita_tcdm_splitter.sv
module tb_ita_tcdm_splitter;

   localparam int unsigned MW = 64;
   localparam int unsigned NP = 2;
   localparam int unsigned AW = NP * MW;
   localparam int unsigned DP = 2;

   logic                     clk = 1'b0;
   logic                     rst_i;
   logic                     wide_req_i;
   logic                     wide_gnt_o;
   logic [31:0]              wide_add_i;
   logic                     wide_wen_i;
   logic [AW/8-1:0]          wide_be_i;
   logic [AW-1:0]            wide_data_i;
   logic [AW-1:0]            wide_r_data_o;
   logic                     wide_r_valid_o;
   logic [NP-1:0]            tcdm_req_o;
   logic [NP-1:0][31:0]      tcdm_add_o;
   logic [NP-1:0]            tcdm_wen_o;
   logic [NP-1:0][MW/8-1:0]  tcdm_be_o;
   logic [NP-1:0][MW-1:0]    tcdm_data_o;
   logic [NP-1:0]            tcdm_gnt_i;
   logic [NP-1:0][MW-1:0]    tcdm_r_data_i;
   logic [NP-1:0]            tcdm_r_valid_i;
   logic                     err_o;

   int checks   = 0;
   int failures = 0;
   logic [AW-1:0] exp_q[$];

   always #5 clk = ~clk;

   ita_tcdm_splitter #(
      .MemDataWidth (MW),
      .MP           (NP),
      .AccDataWidth (AW),
      .Depth        (DP)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .wide_req_i     (wide_req_i),
      .wide_gnt_o     (wide_gnt_o),
      .wide_add_i     (wide_add_i),
      .wide_wen_i     (wide_wen_i),
      .wide_be_i      (wide_be_i),
      .wide_data_i    (wide_data_i),
      .wide_r_data_o  (wide_r_data_o),
      .wide_r_valid_o (wide_r_valid_o),
      .tcdm_req_o     (tcdm_req_o),
      .tcdm_add_o     (tcdm_add_o),
      .tcdm_wen_o     (tcdm_wen_o),
      .tcdm_be_o      (tcdm_be_o),
      .tcdm_data_o    (tcdm_data_o),
      .tcdm_gnt_i     (tcdm_gnt_i),
      .tcdm_r_data_i  (tcdm_r_data_i),
      .tcdm_r_valid_i (tcdm_r_valid_i),
      .err_o          (err_o)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic chk_quiet(input string name);
      chk({name, ".req"},   128'(tcdm_req_o),     128'h0);
      chk({name, ".gnt"},   128'(wide_gnt_o),     128'h0);
      chk({name, ".rv"},    128'(wide_r_valid_o), 128'h0);
      chk({name, ".rdata"}, 128'(wide_r_data_o),  128'h0);
      chk({name, ".err"},   128'(err_o),          128'h0);
   endtask

   // Wide request granted by both ports in one cycle.
   task automatic tx_same(input logic [31:0] addr);
      wide_req_i = 1'b1;
      wide_add_i = addr;
      tcdm_gnt_i = 2'b11;
      mid();
      chk("tx_same.gnt", 128'(wide_gnt_o), 128'h1);
      tick();
      wide_req_i = 1'b0;
      tcdm_gnt_i = 2'b00;
   endtask

   task automatic resp(input logic [MW-1:0] d0, input logic [MW-1:0] d1);
      tcdm_r_valid_i   = 2'b11;
      tcdm_r_data_i[0] = d0;
      tcdm_r_data_i[1] = d1;
      exp_q.push_back({d1, d0});
      tick();
      tcdm_r_valid_i = 2'b00;
   endtask

   // Scoreboard monitor: every wide response must match the oldest expected one.
   always @(negedge clk) begin
      if (wide_r_valid_o) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rvalid actual=%0h expected=none", wide_r_data_o);
         end else begin
            chk("wide_r_data", 128'(wide_r_data_o), 128'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i          = 1'b1;
      wide_req_i     = 1'b1;
      wide_add_i     = 32'h1000;
      wide_wen_i     = 1'b1;
      wide_be_i      = '1;
      wide_data_i    = '0;
      tcdm_gnt_i     = 2'b11;
      tcdm_r_data_i  = '0;
      tcdm_r_valid_i = 2'b00;

      // Reset and the cycle after it: outputs forced quiet despite a live request.
      tick();
      mid();
      chk_quiet("in_reset");
      tick();
      rst_i = 1'b0;
      mid();
      chk_quiet("after_reset");
      tick();
      wide_req_i = 1'b0;
      tcdm_gnt_i = 2'b00;
      tick();

      // Read at 0x1000, both ports grant in the same cycle.
      wide_req_i  = 1'b1;
      wide_add_i  = 32'h1000;
      wide_wen_i  = 1'b1;
      wide_data_i = {64'hBBBB_0000_0000_BBBB, 64'hAAAA_0000_0000_AAAA};
      tcdm_gnt_i  = 2'b11;
      mid();
      chk("same.req",   128'(tcdm_req_o),     128'h3);
      chk("same.add0",  128'(tcdm_add_o[0]),  128'h1000);
      chk("same.add1",  128'(tcdm_add_o[1]),  128'h1008);
      chk("same.wen",   128'(tcdm_wen_o),     128'h3);
      chk("same.data0", 128'(tcdm_data_o[0]), 128'hAAAA_0000_0000_AAAA);
      chk("same.data1", 128'(tcdm_data_o[1]), 128'hBBBB_0000_0000_BBBB);
      chk("same.gnt",   128'(wide_gnt_o),     128'h1);
      tick();
      wide_req_i = 1'b0;
      tcdm_gnt_i = 2'b00;
      tcdm_r_valid_i   = 2'b11;
      tcdm_r_data_i[0] = 64'h11;
      tcdm_r_data_i[1] = 64'h22;
      exp_q.push_back({64'h22, 64'h11});
      mid();
      chk("same.rv_early", 128'(wide_r_valid_o), 128'h0);
      tick();
      tcdm_r_valid_i = 2'b00;
      mid();
      chk("same.rv", 128'(wide_r_valid_o), 128'h1);
      tick();

      // Port 1 grants three cycles after port 0.
      wide_req_i = 1'b1;
      wide_add_i = 32'h2000;
      tcdm_gnt_i = 2'b01;
      mid();
      chk("split.req0", 128'(tcdm_req_o), 128'h3);
      chk("split.gnt0", 128'(wide_gnt_o), 128'h0);
      tick();
      tcdm_gnt_i = 2'b00;
      for (int c = 0; c < 2; c++) begin
         mid();
         chk("split.req_partial", 128'(tcdm_req_o), 128'h2);
         chk("split.gnt_partial", 128'(wide_gnt_o), 128'h0);
         tick();
      end
      tcdm_gnt_i = 2'b10;
      mid();
      chk("split.req3", 128'(tcdm_req_o), 128'h2);
      chk("split.gnt3", 128'(wide_gnt_o), 128'h1);
      tick();
      wide_req_i = 1'b0;
      tcdm_gnt_i = 2'b00;
      mid();
      chk("split.req_idle", 128'(tcdm_req_o), 128'h0);

      // Out-of-order responses: port 0 at t, port 1 at t+4, wide response at t+5.
      tcdm_r_valid_i   = 2'b01;
      tcdm_r_data_i[0] = 64'hA;
      tick();
      tcdm_r_valid_i = 2'b00;
      for (int c = 0; c < 3; c++) begin
         mid();
         chk("ooo.rv_wait", 128'(wide_r_valid_o), 128'h0);
         tick();
      end
      tcdm_r_valid_i   = 2'b10;
      tcdm_r_data_i[1] = 64'hB;
      exp_q.push_back({64'hB, 64'hA});
      mid();
      chk("ooo.rv_t4", 128'(wide_r_valid_o), 128'h0);
      tick();
      tcdm_r_valid_i = 2'b00;
      mid();
      chk("ooo.rv_t5", 128'(wide_r_valid_o), 128'h1);
      tick();

      // Outstanding limit: two grants, third request stalls until a response.
      tx_same(32'h3000);
      tx_same(32'h4000);
      wide_req_i = 1'b1;
      wide_add_i = 32'h5000;
      tcdm_gnt_i = 2'b11;
      for (int c = 0; c < 2; c++) begin
         mid();
         chk("stall.req", 128'(tcdm_req_o), 128'h0);
         chk("stall.gnt", 128'(wide_gnt_o), 128'h0);
         tick();
      end
      tcdm_r_valid_i   = 2'b11;
      tcdm_r_data_i[0] = 64'h31;
      tcdm_r_data_i[1] = 64'h32;
      exp_q.push_back({64'h32, 64'h31});
      mid();
      chk("stall.req_resp", 128'(tcdm_req_o), 128'h0);
      tick();
      tcdm_r_valid_i = 2'b00;
      mid();
      chk("stall.rv",      128'(wide_r_valid_o), 128'h1);
      chk("stall.req_pop", 128'(tcdm_req_o),     128'h0);
      tick();
      mid();
      chk("stall.req_free", 128'(tcdm_req_o), 128'h3);
      chk("stall.gnt_free", 128'(wide_gnt_o), 128'h1);
      tick();
      wide_req_i = 1'b0;
      tcdm_gnt_i = 2'b00;
      resp(64'h41, 64'h42);
      resp(64'h51, 64'h52);
      tick();
      tick();

      // Address wrap plus a write with per-port byte enables.
      wide_req_i  = 1'b1;
      wide_add_i  = 32'hFFFF_FFF8;
      wide_wen_i  = 1'b0;
      wide_be_i   = 16'hF00F;
      tcdm_gnt_i  = 2'b11;
      mid();
      chk("wrap.add0", 128'(tcdm_add_o[0]), 128'hFFFF_FFF8);
      chk("wrap.add1", 128'(tcdm_add_o[1]), 128'h0);
      chk("wrap.wen",  128'(tcdm_wen_o),    128'h0);
      chk("wrap.be0",  128'(tcdm_be_o[0]),  128'h0F);
      chk("wrap.be1",  128'(tcdm_be_o[1]),  128'hF0);
      chk("wrap.gnt",  128'(wide_gnt_o),    128'h1);
      tick();
      wide_req_i = 1'b0;
      tcdm_gnt_i = 2'b00;
      wide_wen_i = 1'b1;
      wide_be_i  = '1;
      resp(64'h61, 64'h62);
      tick();
      tick();

      // Reset while partially granted with one response queued on port 0.
      wide_req_i = 1'b1;
      wide_add_i = 32'h7000;
      tcdm_gnt_i = 2'b01;
      mid();
      chk("rstp.gnt", 128'(wide_gnt_o), 128'h0);
      tick();
      tcdm_gnt_i       = 2'b00;
      tcdm_r_valid_i   = 2'b01;
      tcdm_r_data_i[0] = 64'h71;
      mid();
      chk("rstp.partial", 128'(tcdm_req_o), 128'h2);
      tick();
      tcdm_r_valid_i = 2'b00;
      rst_i          = 1'b1;
      mid();
      chk_quiet("rstp.in_reset");
      tick();
      rst_i      = 1'b0;
      wide_add_i = 32'h8000;
      tcdm_gnt_i = 2'b11;
      mid();
      chk_quiet("rstp.after");
      tick();
      mid();
      chk("rstp.req_fresh", 128'(tcdm_req_o), 128'h3);
      chk("rstp.gnt_fresh", 128'(wide_gnt_o), 128'h1);
      tick();
      wide_req_i       = 1'b0;
      tcdm_gnt_i       = 2'b00;
      tcdm_r_valid_i   = 2'b10;
      tcdm_r_data_i[1] = 64'h82;
      tick();
      tcdm_r_valid_i = 2'b00;
      mid();
      chk("rstp.fifo0_empty", 128'(wide_r_valid_o), 128'h0);
      tick();
      tcdm_r_valid_i   = 2'b01;
      tcdm_r_data_i[0] = 64'h81;
      exp_q.push_back({64'h82, 64'h81});
      tick();
      tcdm_r_valid_i = 2'b00;
      mid();
      chk("rstp.rv", 128'(wide_r_valid_o), 128'h1);
      tick();

      // Overflow port 0's FIFO with unsolicited responses.
      tcdm_r_valid_i   = 2'b01;
      tcdm_r_data_i[0] = 64'h91;
      repeat (3) tick();
      tcdm_r_valid_i = 2'b00;
      for (int c = 0; c < 2; c++) begin
         mid();
`ifdef ITA_TCDM_SPLIT_ERR_EN
         chk("err.sticky", 128'(err_o), 128'h1);
`else
         chk("err.tied", 128'(err_o), 128'h0);
`endif
         chk("err.no_rv", 128'(wide_r_valid_o), 128'h0);
         tick();
      end
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      mid();
      chk("err.cleared", 128'(err_o), 128'h0);
      tick();
      tick();
      mid();
      chk("err.fifo_cleared", 128'(wide_r_valid_o), 128'h0);

      // Drain check: every expected wide response must have been seen.
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
      chk("drain.pending", 128'(exp_q.size()), 128'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
